// File: rtl/adder_seq_ctrl.sv
// Two-requester arbiter that serialises W-bit add/subtract operations through an
// external 4-bit adder, one nibble per cycle, and returns the result on a handshake.
module adder_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid_i,
  output logic                   req0_ready_o,
  input  logic [4*NIBBLES-1:0]   req0_a_i,
  input  logic [4*NIBBLES-1:0]   req0_b_i,
  input  logic                   req0_sub_i,
  input  logic                   req1_valid_i,
  output logic                   req1_ready_o,
  input  logic [4*NIBBLES-1:0]   req1_a_i,
  input  logic [4*NIBBLES-1:0]   req1_b_i,
  input  logic                   req1_sub_i,
  output logic [3:0]             add_a_o,
  output logic [3:0]             add_b_o,
  output logic                   add_cin_o,
  input  logic [3:0]             add_sum_i,
  input  logic                   add_cout_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [4*NIBBLES-1:0]   rsp_sum_o,
  output logic                   rsp_cout_o,
  output logic                   rsp_id_o
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    bx_q, bx_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;
  logic            id_q, id_d;
  logic            ptr_q, ptr_d;
  logic            grant0, grant1;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    bx_d         = bx_q;
    result_d     = result_q;
    carry_d      = carry_q;
    k_d          = k_q;
    id_d         = id_q;
    ptr_d        = ptr_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    add_a_o      = '0;
    add_b_o      = '0;
    add_cin_o    = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_sum_o    = '0;
    rsp_cout_o   = 1'b0;
    rsp_id_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ready is gated by rst_n so it drops immediately on reset assertion
        if (rst_n) begin
          grant0 = req0_valid_i & (~req1_valid_i | ~ptr_q);
          grant1 = req1_valid_i & (~req0_valid_i | ptr_q);
        end
        if (grant0 || grant1) begin
          a_d     = grant1 ? req1_a_i : req0_a_i;
          bx_d    = grant1 ? (req1_sub_i ? ~req1_b_i : req1_b_i)
                           : (req0_sub_i ? ~req0_b_i : req0_b_i);
          carry_d = grant1 ? req1_sub_i : req0_sub_i;
          k_d     = '0;
          id_d    = grant1;
          ptr_d   = grant0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        add_a_o                = a_q[4*k_q +: 4];
        add_b_o                = bx_q[4*k_q +: 4];
        add_cin_o              = carry_q;
        result_d[4*k_q +: 4]   = add_sum_i;
        carry_d                = add_cout_i;
        if (k_q == KW'(NIBBLES - 1)) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        rsp_valid_o = 1'b1;
        rsp_sum_o   = result_q;
        rsp_cout_o  = carry_q;
        rsp_id_o    = id_q;
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      bx_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      id_q     <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: vector table, random ops, arbitration,
// response back-pressure and reset-during-calculation sequences.
module tb_adder_seq_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req0_sub;
  logic req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;
  logic rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 4-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_sub_i   (req0_sub),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_sub_i   (req1_sub),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_cin_o    (add_cin),
    .add_sum_i    (add_sum),
    .add_cout_i   (add_cout),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_sum_o    (rsp_sum),
    .rsp_cout_o   (rsp_cout),
    .rsp_id_o     (rsp_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on every completed response handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  // Present one op, wait for acceptance, follow the nibble sequence, and return at the
  // negedge of the first DONE cycle.
  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] es, input logic ec);
    int t;
    logic [NIBBLES-1:0] cins, ecins;
    logic [W-1:0] bx;
    logic [4:0] s;
    logic c, early;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    #1;
    t = 0;
    while (!(id ? req1_ready : req0_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 20) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: requester %0d never got ready", id);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check("one_ready", 32'(req0_ready & req1_ready), 32'(0));
    exp_q.push_back('{sum: es, cout: ec, id: id});
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    bx = sub ? ~b : b;
    c = sub;
    early = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      ecins[k] = c;
      s = {1'b0, a[4*k +: 4]} + {1'b0, bx[4*k +: 4]} + {4'b0, c};
      c = s[4];
      @(negedge clk);
      cins[k] = add_cin;
      early |= rsp_valid;
    end
    check("cin_seq", 32'(cins), 32'(ecins));
    check("rsp_early", 32'(early), 32'(0));
    @(negedge clk);
    check("latency", 32'(rsp_valid), 32'(1));
    check("done_adder_zero", 32'({add_a, add_b, add_cin}), 32'(0));
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    check("rsp_valid_drop", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    logic [W-1:0] a, b, es;
    logic [W:0] full;
    logic sub, id, ec, gid, both_err, seen;
    int grants, t;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
    vecs[2] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
    vecs[7] = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready = 1'b1;
    #12;
    check("reset_outputs",
          32'({req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id,
               add_a, add_b, add_cin}), 32'(0));
    req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].es, vecs[i].ec);
      finish_rsp();
    end

    for (int i = 0; i < 8; i++) begin
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom_range(0, 1)); id = 1'($urandom_range(0, 1));
      full = {1'b0, a} + {1'b0, b};
      es = sub ? (a - b) : full[W-1:0];
      ec = sub ? (a >= b) : full[W];
      run_op(id, a, b, sub, es, ec);
      finish_rsp();
    end

    // Both requesters valid from reset release: grants must alternate 0,1,0,1
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0020; req1_sub = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    grants = 0; t = 0; both_err = 1'b0;
    #1;
    while (grants < 4 && t < 80) begin
      if (req0_ready && req1_ready) both_err = 1'b1;
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        check("rr_order", 32'(gid), 32'(grants % 2));
        exp_q.push_back('{sum: gid ? 16'h0030 : 16'h0003, cout: 1'b0, id: gid});
        grants++;
        if (grants == 4) begin
          @(posedge clk); #1;
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
      @(negedge clk); #1; t++;
    end
    check("rr_grants", 32'(grants), 32'(4));
    check("rr_both_ready", 32'(both_err), 32'(0));
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin @(negedge clk); t++; end
    check("rr_drain", 32'(exp_q.size()), 32'(0));
    @(negedge clk);

    // Back-pressure: response must hold while rsp_ready stays low
    rsp_ready = 1'b0;
    run_op(1'b0, 16'h4321, 16'h1234, 1'b1, 16'h30ED, 1'b1);
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003; req1_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_data", 32'({rsp_sum, rsp_cout, rsp_id}), 32'({16'h30ED, 1'b1, 1'b0}));
      check("hold_no_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("complete_no_ready", 32'(req1_ready), 32'(0));
    run_op(1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);
    finish_rsp();

    // Reset while nibble 2 is on the adder: everything drops and the op is discarded
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_sub = 1'b0;
    #1; t = 0;
    while (!req0_ready && t < 20) begin @(negedge clk); #1; t++; end
    check("rst_seq_accept", 32'(req0_ready), 32'(1));
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    check("calc_nibble2", 32'(add_a), 32'(2));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id,
               add_a, add_b, add_cin}), 32'(0));
    req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("no_rsp_after_reset", 32'(seen), 32'(0));
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, operand width W = 4*NIBBLES bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester i operation accepted this cycle (valid&ready).
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-007 req0_sub / req1_sub  input  1  1 = A-B, 0 = A+B.
REQ-008 add_a, add_b  output  4  nibble operands to external adder_4bit (A, B).
REQ-009 add_cin  output  1  carry-in to external adder_4bit (Cin).
REQ-010 add_sum  input  4, add_cout  input  1  combinational Sum/Cout returned by adder_4bit.
REQ-011 rsp_valid  output  1, rsp_ready  input  1  result handshake.
REQ-012 rsp_sum  output  W, rsp_cout  output  1, rsp_id  output  1  result, final carry, granted requester index.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: grant = req whose valid is set; both valid -> requester at round-robin pointer; none -> stay IDLE.
REQ-015 reqN_ready SHALL be asserted only in IDLE, only for granted requester, combinationally from valids and pointer; never both.
REQ-016 On accept: latch A, latch B (bitwise inverted if sub), carry <= sub, nibble index k <= 0, id <= grant, pointer <= other requester, go CALC.
REQ-017 CALC cycle k: add_a = A[4k+3:4k], add_b = Bx[4k+3:4k], add_cin = carry; on edge result[4k+3:4k] <= add_sum, carry <= add_cout, k <= k+1.
REQ-018 After nibble NIBBLES-1 captured: go DONE; rsp_sum = result, rsp_cout = final carry, rsp_id = id.
REQ-019 Latency: accept at edge t -> CALC edges t+1..t+NIBBLES -> rsp_valid high from cycle after edge t+NIBBLES (5 cycles for NIBBLES=4).
REQ-020 Subtraction: rsp_sum = (A-B) mod 2^W; rsp_cout = 1 iff A >= B (no borrow).
REQ-021 Addition: rsp_sum = (A+B) mod 2^W; rsp_cout = bit W of A+B.
REQ-022 DONE: rsp_valid=1, rsp_sum/cout/id stable until rsp_valid&rsp_ready; then IDLE (rsp_valid low next cycle).
REQ-023 No new request accepted while CALC or DONE; requesters hold valid and operands until ready.
REQ-024 add_a, add_b, add_cin SHALL be 0 in IDLE and DONE.
REQ-025 Same-cycle response completion and new valid: new request accepted earliest the cycle after returning to IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, pointer 0 (req0 favored), rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, req*_ready 0, add_* 0, k 0, carry 0.
REQ-027 Reset during CALC or DONE SHALL discard the operation; no rsp_valid after release unless a new request is accepted.

Verification
REQ-028 req0: A=0x1234, B=0x0FFF, sub=0 -> rsp_sum 0x2233, rsp_cout 0, rsp_id 0, rsp_valid 5 cycles after accept; add_cin sequence 0,1,1,1.
REQ-029 req1: A=0x0005, B=0x0007, sub=1 -> 0xFFFE, cout 0; then A=0x0007, B=0x0005, sub=1 -> 0x0002, cout 1.
REQ-030 A=0xFFFF, B=0x0001, sub=0 -> rsp_sum 0x0000, rsp_cout 1; carry propagates all 4 nibbles.
REQ-031 Both valid continuously from reset release -> grants req0, req1, req0, req1 (rsp_id 0,1,0,1); ready never on both.
REQ-032 rsp_ready held low 3 cycles in DONE -> rsp_sum/cout/id unchanged, req0_ready/req1_ready 0 throughout.
REQ-033 rst_n low during CALC nibble 2 -> all outputs 0 asynchronously; after release with no valid, rsp_valid stays 0.
